mem_responder: RTL and testbench



---
 rtl/mem_responder_if.sv | 27 ++
 rtl/mem_responder.sv | 140 ++++++++++++++
 tb/tb_mem_responder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Core bus and boot-loader byte stream between the host/core side and the responder.
// No storage; pure signal bundle.
// Loader side follows valid/ready; the core bus has no backpressure (zero wait states).
interface mem_responder_if;
  // Core bus
  logic [15:0] address;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  // Boot loader byte stream
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_ready;

  // Core plus loader side
  modport master (
    output address, wr_en, wr_data, load_valid, load_data, load_last,
    input  rd_data, load_ready
  );

  // Memory responder side
  modport slave (
    input  address, wr_en, wr_data, load_valid, load_data, load_last,
    output rd_data, load_ready
  );
endinterface

// File: rtl/mem_responder.sv
// Memory responder: RAM/ROM decode for the core plus a boot loader that fills ROM before releasing the core.
// Reads are combinational (zero wait states); writes and loader accepts take effect on the rising edge.
// load_ready is high only in LOAD; bytes offered in RELEASE/RUN are dropped, never stalled.
module mem_responder #(
  parameter int         RAM_AW         = 11,
  parameter int         ROM_AW         = 12,
  parameter int         RELEASE_CYCLES = 4,
  parameter logic [7:0] UNMAPPED_DATA  = 8'hFF
) (
  input  logic              clk,
  input  logic              resetn,
  mem_responder_if.slave    bus,
  output logic              cpu_resetn,
  output logic [ROM_AW:0]   load_count,
  output logic              running
);

  localparam int          RAM_SIZE = 1 << RAM_AW;
  localparam int          ROM_SIZE = 1 << ROM_AW;
  localparam int          CNT_W    = ROM_AW + 1;
  // 17-bit bounds so that a 64 KiB region still has a representable end
  localparam logic [16:0] RAM_END  = 17'(RAM_SIZE);
  localparam logic [16:0] ROM_BASE = 17'(65536 - ROM_SIZE);
  localparam int          RCW      = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_LOAD    = 3'b001,
    ST_RELEASE = 3'b010,
    ST_RUN     = 3'b100
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [RCW-1:0]   rel_q, rel_d;
  logic             cpu_resetn_q;

  logic [7:0] ram_q [RAM_SIZE];
  logic [7:0] rom_q [ROM_SIZE];

  logic        load_ready_int;
  logic        accept;
  logic        rom_full_byte;
  logic        in_ram;
  logic        in_rom;
  logic        ram_we;
  logic [16:0] addr_ext;

  // Loader is only ready in LOAD and never while reset is held
  assign load_ready_int = resetn && (state_q == ST_LOAD);
  assign accept         = bus.load_valid && load_ready_int;
  // The byte being accepted is the last slot of the ROM
  assign rom_full_byte  = (count_q == CNT_W'(ROM_SIZE - 1));

  assign addr_ext = {1'b0, bus.address};
  assign in_rom   = (addr_ext >= ROM_BASE);
  assign in_ram   = (addr_ext < RAM_END);
  // ROM takes priority if a bad parameter set makes the regions overlap
  assign ram_we   = (state_q == ST_RUN) && bus.wr_en && in_ram && !in_rom;

  // Next-state logic for the load / release / run sequence
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rel_d   = rel_q;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          count_d = count_q + 1'b1;
          if (bus.load_last || rom_full_byte) begin
            state_d = ST_RELEASE;
            rel_d   = RCW'(RELEASE_CYCLES - 1);
          end
        end
      end
      ST_RELEASE: begin
        if (rel_q == '0) begin
          state_d = ST_RUN;
        end else begin
          rel_d = rel_q - 1'b1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        // Illegal one-hot code: restart the boot sequence cleanly
        state_d = ST_LOAD;
        count_d = '0;
        rel_d   = '0;
      end
    endcase
  end

  // State, counters and the registered core reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_LOAD;
      count_q      <= '0;
      rel_q        <= '0;
      cpu_resetn_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rel_q        <= rel_d;
      cpu_resetn_q <= (state_d == ST_RUN);
    end
  end

  // ROM fill from the loader stream; contents survive reset
  always_ff @(posedge clk) begin
    if (accept) begin
      rom_q[count_q[ROM_AW-1:0]] <= bus.load_data;
    end
  end

  // Core writes into RAM; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[bus.address[RAM_AW-1:0]] <= bus.wr_data;
    end
  end

  // Asynchronous read decode; nothing is visible to the core until RUN
  always_comb begin
    bus.rd_data = UNMAPPED_DATA;
    if (state_q == ST_RUN) begin
      if (in_rom) begin
        bus.rd_data = rom_q[bus.address[ROM_AW-1:0]];
      end else if (in_ram) begin
        bus.rd_data = ram_q[bus.address[RAM_AW-1:0]];
      end
    end
  end

  assign bus.load_ready = load_ready_int;
  assign cpu_resetn     = cpu_resetn_q;
  assign load_count     = count_q;
  assign running        = (state_q == ST_RUN);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: boot loading, release timing, decode and RAM writes.
// Inputs change 1 time unit after the rising edge; outputs are checked away from the edge.
// Every comparison is an immediate assertion that counts and reports its own failure.
module tb_mem_responder;

  logic        clk;
  logic        resetn;
  logic        cpu_resetn;
  logic [12:0] load_count;
  logic        running;
  int          checks;
  int          errors;

  mem_responder_if bus();

  mem_responder #(
    .RAM_AW        (11),
    .ROM_AW        (12),
    .RELEASE_CYCLES(4),
    .UNMAPPED_DATA (8'hFF)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus.slave),
    .cpu_resetn(cpu_resetn),
    .load_count(load_count),
    .running   (running)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one loader byte for exactly one rising edge
  task automatic send(input logic [7:0] d, input logic last);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    tick();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
    bus.address = a;
    #1;
    chk(tag, {8'h00, bus.rd_data}, {8'h00, exp});
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.address = a;
    bus.wr_data = d;
    bus.wr_en   = 1'b1;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    for (int i = 0; i < 20 && !running; i++) tick();
    chk(tag, {15'd0, running}, 16'd1);
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    #3;
    resetn = 1'b1;
    tick();
  endtask

  // Contents of the full 4096-byte image: reset vector F000 at FFC/FFD
  function automatic logic [7:0] pat1(input int i);
    if (i == 12'hFFC) return 8'h00;
    if (i == 12'hFFD) return 8'hF0;
    return 8'(i) ^ 8'h5A;
  endfunction

  initial begin
    checks         = 0;
    errors         = 0;
    resetn         = 1'b0;
    bus.address    = 16'hFFFC;
    bus.wr_en      = 1'b0;
    bus.wr_data    = 8'h00;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    bus.load_last  = 1'b0;

    // ---- reset state ----
    #12;
    chk("rst_cpu_resetn", {15'd0, cpu_resetn}, 16'd0);
    chk("rst_running", {15'd0, running}, 16'd0);
    chk("rst_load_ready", {15'd0, bus.load_ready}, 16'd0);
    chk("rst_load_count", {3'd0, load_count}, 16'd0);
    rd("rst_rd_fffc", 16'hFFFC, 8'hFF);
    resetn = 1'b1;
    tick();
    chk("load_ready_in_load", {15'd0, bus.load_ready}, 16'd1);

    // ---- full ROM stream, load_last never set ----
    for (int i = 0; i < 4095; i++) send(pat1(i), 1'b0);
    chk("full_cnt_4095", {3'd0, load_count}, 16'd4095);
    chk("full_ready_before_last", {15'd0, bus.load_ready}, 16'd1);
    rd("load_rd_fffc", 16'hFFFC, 8'hFF);
    send(pat1(4095), 1'b0);
    chk("full_cnt_4096", {3'd0, load_count}, 16'd4096);
    chk("full_ready_after", {15'd0, bus.load_ready}, 16'd0);
    chk("full_cpu_rst_e0", {15'd0, cpu_resetn}, 16'd0);
    // loader keeps offering bytes during RELEASE; they must be dropped
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h77;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("rel_cpu_resetn_low", {15'd0, cpu_resetn}, 16'd0);
      chk("rel_cnt_held", {3'd0, load_count}, 16'd4096);
    end
    tick();
    chk("rel_cpu_resetn_rise", {15'd0, cpu_resetn}, 16'd1);
    chk("run_running", {15'd0, running}, 16'd1);
    chk("run_ready_low", {15'd0, bus.load_ready}, 16'd0);
    chk("run_cnt_held", {3'd0, load_count}, 16'd4096);
    bus.load_valid = 1'b0;
    rd("vec_lo", 16'hFFFC, 8'h00);
    rd("vec_hi", 16'hFFFD, 8'hF0);
    rd("rom_f000", 16'hF000, 8'h5A);
    rd("rom_f123", 16'hF123, 8'h79);
    rd("rom_ffff", 16'hFFFF, 8'hA5);

    // ---- RAM writes and decode in RUN ----
    wr(16'h0123, 8'h11);
    bus.address = 16'h0123;
    bus.wr_data = 8'h3C;
    bus.wr_en   = 1'b1;
    #1;
    chk("ram_old_same_cycle", {8'h00, bus.rd_data}, 16'h0011);
    tick();
    bus.wr_en = 1'b0;
    chk("ram_new_next_cycle", {8'h00, bus.rd_data}, 16'h003C);
    wr(16'hF000, 8'hAA);
    rd("rom_write_ignored", 16'hF000, 8'h5A);
    wr(16'h4000, 8'h12);
    rd("unmapped_4000", 16'h4000, 8'hFF);
    wr(16'h07FF, 8'h42);
    rd("ram_top_07ff", 16'h07FF, 8'h42);
    rd("unmapped_0800", 16'h0800, 8'hFF);
    rd("unmapped_efff", 16'hEFFF, 8'hFF);

    // ---- asynchronous reset in RUN, then a load interrupted by reset ----
    #2;
    resetn = 1'b0;
    #1;
    chk("async_cpu_resetn", {15'd0, cpu_resetn}, 16'd0);
    chk("async_running", {15'd0, running}, 16'd0);
    chk("async_cnt", {3'd0, load_count}, 16'd0);
    resetn = 1'b1;
    tick();
    // core writes outside RUN are ignored
    wr(16'h0123, 8'h99);
    rd("load_rd_fffc_again", 16'hFFFC, 8'hFF);
    for (int i = 0; i < 60; i++) send(8'h80 + 8'(i), 1'b0);
    chk("mid_cnt_60", {3'd0, load_count}, 16'd60);
    resetn = 1'b0;
    #1;
    chk("mid_rst_cnt", {3'd0, load_count}, 16'd0);
    chk("mid_rst_ready", {15'd0, bus.load_ready}, 16'd0);
    resetn = 1'b1;
    tick();
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b1);
    chk("reload_cnt_2", {3'd0, load_count}, 16'd2);
    wait_run("reload_run");
    rd("reload_b0", 16'hF000, 8'hC1);
    rd("reload_b1", 16'hF001, 8'hC2);
    rd("old_b2", 16'hF002, 8'h82);
    rd("old_b59", 16'hF03B, 8'hBB);
    rd("older_b60", 16'hF03C, 8'h66);
    rd("ram_load_write_ignored", 16'h0123, 8'h3C);

    // ---- short load with gaps, valid held through RELEASE ----
    pulse_reset();
    send(8'hA9, 1'b0);
    tick();
    chk("gap_cnt_1", {3'd0, load_count}, 16'd1);
    send(8'h5A, 1'b0);
    tick();
    tick();
    chk("gap_cnt_2", {3'd0, load_count}, 16'd2);
    send(8'hEA, 1'b1);
    chk("short_cnt_3", {3'd0, load_count}, 16'd3);
    chk("short_ready_low", {15'd0, bus.load_ready}, 16'd0);
    rd("short_rel_rd", 16'hF001, 8'hFF);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h55;
    tick();
    tick();
    chk("short_rel_cnt_held", {3'd0, load_count}, 16'd3);
    wait_run("short_run");
    bus.load_valid = 1'b0;
    chk("short_cnt_final", {3'd0, load_count}, 16'd3);
    rd("short_f001", 16'hF001, 8'h5A);
    rd("short_f000", 16'hF000, 8'hA9);
    rd("short_f002", 16'hF002, 8'hEA);
    rd("short_f003_old", 16'hF003, 8'h83);
    rd("short_vec_lo", 16'hFFFC, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
